// File: rtl/eight_bit_minmax_tracker_if.sv
// Bus bundle for eight_bit_minmax_tracker: sample stream in, burst results out.
// Handshake: a sample transfers on any rising clock edge where in_valid and
// in_ready are both high. in_ready is a registered function of the FSM state
// and never depends combinationally on in_valid. The source may hold or drop
// in_valid at any time; a low in_valid simply stalls the burst.
interface eight_bit_minmax_tracker_if;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic [7:0] max_out;
    logic [7:0] min_out;
    logic [7:0] max_index;
    logic [7:0] min_index;
    logic [7:0] eq_max_count;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, busy, done, max_out, min_out,
        input  max_index, min_index, eq_max_count
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, busy, done, max_out, min_out,
        output max_index, min_index, eq_max_count
    );
endinterface

// File: rtl/eight_bit_minmax_tracker.sv
// Burst min/max tracker. Accepts N_SAMPLES unsigned bytes per burst and
// reports the largest and smallest sample plus the index of the first
// occurrence of each, with a one-cycle done pulse.
// Optional feature: define MINMAX_EQ_COUNT_EN to build the saturating
// count of samples equal to the final maximum; otherwise eq_max_count is 0.

// Unsigned magnitude comparator; rel encodes a against b.
module eight_bit_comparator (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [1:0] rel
);
    // 2'b10 = greater, 2'b01 = less, 2'b00 = equal
    always_comb begin
        rel = 2'b00;
        if (a > b)      rel = 2'b10;
        else if (a < b) rel = 2'b01;
    end
endmodule

module eight_bit_minmax_tracker #(
    parameter int N_SAMPLES = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    eight_bit_minmax_tracker_if.slave   bus,
    output logic [1:0]                  state_dbg
);
    localparam logic [1:0] REL_GT = 2'b10;
    localparam logic [1:0] REL_LT = 2'b01;
    localparam logic [1:0] REL_EQ = 2'b00;
    localparam logic [7:0] LAST_IDX = 8'(N_SAMPLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t     state, next_state;
    logic [7:0] idx;
    logic [7:0] run_max, run_min, run_max_idx, run_min_idx;
    logic [7:0] nx_max, nx_min, nx_max_idx, nx_min_idx;
    logic [1:0] max_rel, min_rel;
    logic       xfer, last_xfer;
    logic       in_ready_q, busy_q, done_q;
    logic [7:0] max_q, min_q, max_idx_q, min_idx_q;
`ifdef MINMAX_EQ_COUNT_EN
    logic [7:0] run_eq, nx_eq, eq_q;
`endif

    assign xfer      = bus.in_valid && in_ready_q;
    assign last_xfer = (state == RUN) && xfer && (idx == LAST_IDX);
    assign state_dbg = state;

    eight_bit_comparator cmp_max (.a(bus.in_data), .b(run_max), .rel(max_rel));
    eight_bit_comparator cmp_min (.a(bus.in_data), .b(run_min), .rel(min_rel));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = LOAD;
            LOAD:    if (xfer) next_state = RUN;
            RUN:     if (last_xfer) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Candidate running values after accepting the current sample
    always_comb begin
        nx_max     = run_max;
        nx_min     = run_min;
        nx_max_idx = run_max_idx;
        nx_min_idx = run_min_idx;
`ifdef MINMAX_EQ_COUNT_EN
        nx_eq      = run_eq;
`endif
        if (state == LOAD) begin
            nx_max     = bus.in_data;
            nx_min     = bus.in_data;
            nx_max_idx = 8'd0;
            nx_min_idx = 8'd0;
`ifdef MINMAX_EQ_COUNT_EN
            nx_eq      = 8'd1;
`endif
        end else if (state == RUN) begin
            // Ties leave the index alone so the first occurrence wins
            if (max_rel == REL_GT) begin
                nx_max     = bus.in_data;
                nx_max_idx = idx;
`ifdef MINMAX_EQ_COUNT_EN
                nx_eq      = 8'd1;
`endif
            end else if (max_rel == REL_EQ) begin
`ifdef MINMAX_EQ_COUNT_EN
                if (run_eq != 8'hFF) nx_eq = run_eq + 8'd1;
`endif
            end
            if (min_rel == REL_LT) begin
                nx_min     = bus.in_data;
                nx_min_idx = idx;
            end
        end
    end

    // Running registers and sample index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx         <= 8'd0;
            run_max     <= 8'd0;
            run_min     <= 8'd0;
            run_max_idx <= 8'd0;
            run_min_idx <= 8'd0;
`ifdef MINMAX_EQ_COUNT_EN
            run_eq      <= 8'd0;
`endif
        end else if (state == IDLE && bus.start) begin
            idx         <= 8'd0;
`ifdef MINMAX_EQ_COUNT_EN
            run_eq      <= 8'd0;
`endif
        end else if (xfer) begin
            idx         <= idx + 8'd1;
            run_max     <= nx_max;
            run_min     <= nx_min;
            run_max_idx <= nx_max_idx;
            run_min_idx <= nx_min_idx;
`ifdef MINMAX_EQ_COUNT_EN
            run_eq      <= nx_eq;
`endif
        end
    end

    // Result registers: loaded on the final accept so they change with done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_q     <= 8'd0;
            min_q     <= 8'd0;
            max_idx_q <= 8'd0;
            min_idx_q <= 8'd0;
`ifdef MINMAX_EQ_COUNT_EN
            eq_q      <= 8'd0;
`endif
        end else if (last_xfer) begin
            max_q     <= nx_max;
            min_q     <= nx_min;
            max_idx_q <= nx_max_idx;
            min_idx_q <= nx_min_idx;
`ifdef MINMAX_EQ_COUNT_EN
            eq_q      <= nx_eq;
`endif
        end
    end

    // Registered status flags, decoded from the upcoming state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            in_ready_q <= (next_state == LOAD) || (next_state == RUN);
            busy_q     <= (next_state == LOAD) || (next_state == RUN);
            done_q     <= (next_state == DONE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.max_out   = max_q;
    assign bus.min_out   = min_q;
    assign bus.max_index = max_idx_q;
    assign bus.min_index = min_idx_q;
`ifdef MINMAX_EQ_COUNT_EN
    assign bus.eq_max_count = eq_q;
`else
    assign bus.eq_max_count = 8'd0;
`endif
endmodule
